// File: rtl/booth_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : booth_pkg                                                  |
// | Description : Shared definitions for the radix-2 Booth multiplier:       |
// |               default operand width, control strobe encoding and the     |
// |               bit positions of the lookahead vector sent to control.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package booth_pkg;

  // Default operand width; datapath and control FSM must agree on it.
  localparam int N_LEN_DEFAULT = 8;

  // Positions inside the 3-bit lookahead vector {Q[1], Q[0], Q-1}.
  localparam int Q_M1 = 0;
  localparam int Q_0  = 1;
  localparam int Q_1  = 2;

  // Datapath operation selected by the control strobes.
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_ADD   = 2'd1,
    OP_SUB   = 2'd2,
    OP_SHIFT = 2'd3
  } op_e;

  // Resolve the strobes to one operation: shift > sub > add.
  function automatic op_e decode_op(input logic add_s, input logic sub_s,
                                    input logic ashift_s);
    op_e op;
    op = OP_HOLD;
    if (ashift_s)   op = OP_SHIFT;
    else if (sub_s) op = OP_SUB;
    else if (add_s) op = OP_ADD;
    return op;
  endfunction

  // True when more than one strobe is active in the same cycle.
  function automatic logic multi_strobe(input logic add_s, input logic sub_s,
                                        input logic ashift_s);
    return (add_s & sub_s) | (add_s & ashift_s) | (sub_s & ashift_s);
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_addsub.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : booth_addsub                                               |
// | Description : Combinational (N_LEN+1)-bit add/subtract of the            |
// |               accumulator and the sign-extended multiplicand.            |
// | Ports       : i_a      [N_LEN:0]   accumulator (with guard bit)          |
// |               i_m      [N_LEN-1:0] multiplicand                          |
// |               i_sub    1           1 = subtract, 0 = add                 |
// |               o_result [N_LEN:0]   result modulo 2^(N_LEN+1)             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module booth_addsub
  import booth_pkg::*;
#(
  parameter int N_LEN = N_LEN_DEFAULT
) (
  input  logic [N_LEN:0]   i_a,
  input  logic [N_LEN-1:0] i_m,
  input  logic             i_sub,
  output logic [N_LEN:0]   o_result
);

  logic [N_LEN:0] w_m_ext;

  // Guard-bit sign extension keeps -2^(N_LEN-1) representable after negation.
  assign w_m_ext  = {i_m[N_LEN-1], i_m};
  assign o_result = i_sub ? (i_a - w_m_ext) : (i_a + w_m_ext);

endmodule
`default_nettype wire

// File: rtl/booth_datapath.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : booth_datapath                                             |
// | Description : Radix-2 Booth multiplier datapath. Holds A (with guard     |
// |               bit), Q, Q-1 and M, executes control strobes, returns      |
// |               lookahead bits and captures the product on completion.     |
// | Ports       : Clock, nReset (async, active-low)                          |
// |               Request, Multiplicand, Multiplier  - operand load          |
// |               add_s, sub_s, ashift_s, Done       - from control FSM      |
// |               Q [2:0]        {Q[1], Q[0], Q-1} to control FSM            |
// |               Product        signed 2*N_LEN result                       |
// |               Product_valid  Product holds a completed result            |
// |               Ctrl_err       sticky illegal-strobe flag                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module booth_datapath
  import booth_pkg::*;
#(
  parameter int N_LEN = N_LEN_DEFAULT
) (
  input  logic               Clock,
  input  logic               nReset,
  input  logic               Request,
  input  logic [N_LEN-1:0]   Multiplicand,
  input  logic [N_LEN-1:0]   Multiplier,
  input  logic               add_s,
  input  logic               sub_s,
  input  logic               ashift_s,
  input  logic               Done,
  output logic [2:0]         Q,
  output logic [2*N_LEN-1:0] Product,
  output logic               Product_valid,
  output logic               Ctrl_err
);

  logic [N_LEN:0]     r_a;
  logic [N_LEN-1:0]   r_q;
  logic               r_qm1;
  logic [N_LEN-1:0]   r_m;
  logic               r_done_d;
  logic [2*N_LEN-1:0] r_product;
  logic               r_product_valid;
  logic               r_ctrl_err;

  logic               w_load;
  logic               w_complete;
  logic               w_strobe_any;
  logic               w_bad_strobe;
  op_e                w_op;
  logic [N_LEN:0]     w_addsub;

  assign w_load       = Request & Done;
  assign w_complete   = Done & ~r_done_d;
  assign w_strobe_any = add_s | sub_s | ashift_s;
  assign w_op         = decode_op(add_s, sub_s, ashift_s);
  // A strobe colliding with a load is as illegal as two strobes at once.
  assign w_bad_strobe = multi_strobe(add_s, sub_s, ashift_s) | (w_load & w_strobe_any);

  booth_addsub #(
    .N_LEN (N_LEN)
  ) u_addsub (
    .i_a      (r_a),
    .i_m      (r_m),
    .i_sub    (w_op == OP_SUB),
    .o_result (w_addsub)
  );

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_a             <= '0;
      r_q             <= '0;
      r_qm1           <= 1'b0;
      r_m             <= '0;
      r_done_d        <= 1'b1;
      r_product       <= '0;
      r_product_valid <= 1'b0;
      r_ctrl_err      <= 1'b0;
    end else begin
      r_done_d <= Done;

      if (w_bad_strobe) begin
        r_ctrl_err <= 1'b1;
      end

      if (w_load) begin
        r_a   <= '0;
        r_q   <= Multiplier;
        r_qm1 <= 1'b0;
        r_m   <= Multiplicand;
      end else begin
        case (w_op)
          // Arithmetic shift of the whole {A,Q,Q-1} chain by one bit.
          OP_SHIFT: {r_a, r_q, r_qm1} <= {r_a[N_LEN], r_a, r_q};
          OP_ADD,
          OP_SUB:   r_a <= w_addsub;
          default:  ;
        endcase
      end

      // Completion outranks a coincident load so the finished result survives.
      if (w_complete) begin
        r_product       <= {r_a[N_LEN-1:0], r_q};
        r_product_valid <= 1'b1;
      end else if (w_load) begin
        r_product_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    Q       = '0;
    Q[Q_1]  = r_q[1];
    Q[Q_0]  = r_q[0];
    Q[Q_M1] = r_qm1;
  end

  assign Product       = r_product;
  assign Product_valid = r_product_valid;
  assign Ctrl_err      = r_ctrl_err;

endmodule
`default_nettype wire

// File: tb/tb_booth_datapath.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_booth_datapath                                          |
// | Description : Self-checking bench for booth_datapath. A word-level       |
// |               model of {A,Q,Q-1} is compared every cycle; full Booth     |
// |               operations are checked against plain multiplication.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_booth_datapath;

  localparam int N = 8;
  localparam int W = 2*N + 2;

  logic           Clock = 1'b0;
  logic           nReset = 1'b1;
  logic           Request = 1'b0;
  logic           add_s = 1'b0;
  logic           sub_s = 1'b0;
  logic           ashift_s = 1'b0;
  logic           Done = 1'b1;
  logic [N-1:0]   Multiplicand = '0;
  logic [N-1:0]   Multiplier = '0;
  logic [2:0]     Q;
  logic [2*N-1:0] Product;
  logic           Product_valid;
  logic           Ctrl_err;

  int   checks = 0;
  int   errors = 0;
  logic run_cmp = 1'b0;

  always #5 Clock = ~Clock;

  booth_datapath #(
    .N_LEN (N)
  ) dut (
    .Clock         (Clock),
    .nReset        (nReset),
    .Request       (Request),
    .Multiplicand  (Multiplicand),
    .Multiplier    (Multiplier),
    .add_s         (add_s),
    .sub_s         (sub_s),
    .ashift_s      (ashift_s),
    .Done          (Done),
    .Q             (Q),
    .Product       (Product),
    .Product_valid (Product_valid),
    .Ctrl_err      (Ctrl_err)
  );

  // Model: the working state is one 2N+2-bit word {A,Q,Q-1}; add/sub touch
  // only the top N+1 bits, shift is a signed divide-by-two of the word.
  logic [W-1:0]   m_w;
  logic [N-1:0]   m_m;
  logic [2*N-1:0] m_prod;
  logic           m_valid, m_err, m_done_d;

  function automatic logic [W-1:0] m_addend(input logic [N-1:0] m);
    return {m[N-1], m, {(N+1){1'b0}}};
  endfunction

  function automatic logic [2*N-1:0] mul_ref(input logic [N-1:0] a, input logic [N-1:0] b);
    int p;
    p = $signed(a) * $signed(b);
    return p[2*N-1:0];
  endfunction

  always @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      m_w <= '0; m_m <= '0; m_prod <= '0;
      m_valid <= 1'b0; m_err <= 1'b0; m_done_d <= 1'b1;
    end else begin
      m_done_d <= Done;
      if ((int'(add_s) + int'(sub_s) + int'(ashift_s) > 1) ||
          (Request && Done && (add_s || sub_s || ashift_s)))
        m_err <= 1'b1;
      if (Done && !m_done_d) begin
        m_prod  <= m_w[2*N:1];
        m_valid <= 1'b1;
      end else if (Request && Done) begin
        m_valid <= 1'b0;
      end
      if (Request && Done) begin
        m_w <= {{(N+1){1'b0}}, Multiplier, 1'b0};
        m_m <= Multiplicand;
      end else if (ashift_s) m_w <= $signed(m_w) >>> 1;
      else if (sub_s)        m_w <= m_w - m_addend(m_m);
      else if (add_s)        m_w <= m_w + m_addend(m_m);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    if (run_cmp) begin
      check("model_Q",     32'(Q),             32'(m_w[2:0]));
      check("model_prod",  32'(Product),       32'(m_prod));
      check("model_valid", 32'(Product_valid), 32'(m_valid));
      check("model_err",   32'(Ctrl_err),      32'(m_err));
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_load(input logic [N-1:0] a, input logic [N-1:0] b);
    Multiplicand = a; Multiplier = b; Request = 1'b1; Done = 1'b1;
    tick();
    Request = 1'b0; Done = 1'b0;
    Multiplicand = N'($urandom); Multiplier = N'($urandom);
  endtask

  // Simple sequential Booth control: inspect {Q[0],Q-1}, add/sub, shift.
  task automatic do_steps(input int glitch, output int nadd, output int nsub, output int nshift);
    logic [2:0] q_before;
    nadd = 0; nsub = 0; nshift = 0;
    for (int i = 0; i < N; i++) begin
      if (i == glitch) begin
        q_before = Q;
        Request = 1'b1; Multiplicand = N'($urandom); Multiplier = N'($urandom);
        tick();
        Request = 1'b0;
        check("glitch_q_hold", 32'(Q), 32'(q_before));
      end
      if (Q[1:0] == 2'b01) begin
        add_s = 1'b1; tick(); add_s = 1'b0; nadd++;
      end else if (Q[1:0] == 2'b10) begin
        sub_s = 1'b1; tick(); sub_s = 1'b0; nsub++;
      end
      ashift_s = 1'b1; tick(); ashift_s = 1'b0; nshift++;
    end
  endtask

  task automatic do_finish(input logic req_next, input logic [N-1:0] a, input logic [N-1:0] b);
    Done = 1'b1; Request = req_next; Multiplicand = a; Multiplier = b;
    tick();
    Request = 1'b0;
    if (req_next) Done = 1'b0;
  endtask

  task automatic full_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                         input int glitch);
    int na, ns, nsh;
    do_load(a, b);
    do_steps(glitch, na, ns, nsh);
    do_finish(1'b0, '0, '0);
    check({name, "_product"}, 32'(Product), 32'(mul_ref(a, b)));
    check({name, "_valid"},   32'(Product_valid), 32'd1);
  endtask

  initial begin
    int na, ns, nsh;
    logic [N-1:0] ra, rb;

    #2 nReset = 1'b0;
    #20;
    check("reset_Q",     32'(Q),             32'd0);
    check("reset_prod",  32'(Product),       32'd0);
    check("reset_valid", 32'(Product_valid), 32'd0);
    check("reset_err",   32'(Ctrl_err),      32'd0);
    nReset = 1'b1;
    run_cmp = 1'b1;
    tick();

    // 3 * 5
    do_load(8'd3, 8'd5);
    check("load_Q_3x5", 32'(Q), 32'b010);
    do_steps(-1, na, ns, nsh);
    do_finish(1'b0, '0, '0);
    check("prod_3x5",  32'(Product),       32'h000F);
    check("valid_3x5", 32'(Product_valid), 32'd1);

    // Guard-bit case and negative multiplier
    do_load(8'h80, 8'h80); do_steps(-1, na, ns, nsh); do_finish(1'b0, '0, '0);
    check("prod_m128sq", 32'(Product), 32'h4000);
    do_load(8'd7, 8'hFF); do_steps(-1, na, ns, nsh); do_finish(1'b0, '0, '0);
    check("prod_7xm1", 32'(Product), 32'hFFF9);

    // Zero multiplier: shifts only
    do_load(8'h5A, 8'h00); do_steps(-1, na, ns, nsh); do_finish(1'b0, '0, '0);
    check("zero_addsub", 32'(na + ns), 32'd0);
    check("zero_shifts", 32'(nsh),     32'd8);
    check("zero_prod",   32'(Product), 32'd0);

    // Back-to-back: load on completion edge keeps first result valid
    do_load(8'd11, 8'hFA); do_steps(-1, na, ns, nsh);
    do_finish(1'b1, 8'hFD, 8'd9);
    check("b2b_valid1", 32'(Product_valid), 32'd1);
    check("b2b_prod1",  32'(Product),       32'(mul_ref(8'd11, 8'hFA)));
    check("b2b_loadQ",  32'(Q),             32'b010);
    do_steps(-1, na, ns, nsh);
    do_finish(1'b0, '0, '0);
    check("b2b_prod2",  32'(Product), 32'hFFE5);
    do_load(8'd1, 8'd1);
    check("b2b_reload_valid", 32'(Product_valid), 32'd0);
    do_steps(-1, na, ns, nsh); do_finish(1'b0, '0, '0);
    check("b2b_prod3", 32'(Product), 32'd1);

    // Request pulse while busy is ignored
    full_op("glitch", 8'hD3, 8'd77, 3);

    // Illegal strobe combination is sticky
    Done = 1'b0; add_s = 1'b1; sub_s = 1'b1; tick(); add_s = 1'b0; sub_s = 1'b0;
    check("err_set", 32'(Ctrl_err), 32'd1);
    repeat (3) tick();
    check("err_sticky", 32'(Ctrl_err), 32'd1);
    Done = 1'b1; tick();

    // Reset in the middle of an operation
    do_load(8'd25, 8'd13);
    ashift_s = 1'b1; tick(); tick(); ashift_s = 1'b0;
    nReset = 1'b0; Done = 1'b1;
    #1;
    check("midrst_Q",     32'(Q),             32'd0);
    check("midrst_prod",  32'(Product),       32'd0);
    check("midrst_valid", 32'(Product_valid), 32'd0);
    check("midrst_err",   32'(Ctrl_err),      32'd0);
    tick();
    nReset = 1'b1;
    repeat (3) tick();
    check("postrst_valid", 32'(Product_valid), 32'd0);

    // Random full operations against plain multiplication
    for (int k = 0; k < 24; k++) begin
      ra = N'($urandom); rb = N'($urandom);
      full_op("rand_op", ra, rb, int'($urandom_range(0, 2*N)));
    end

    // Random raw stimulus, checked cycle by cycle by the model
    for (int k = 0; k < 1500; k++) begin
      Request      = ($urandom_range(0, 3) == 0);
      Done         = $urandom_range(0, 1) == 1;
      add_s        = ($urandom_range(0, 2) == 0);
      sub_s        = ($urandom_range(0, 3) == 0);
      ashift_s     = ($urandom_range(0, 2) == 0);
      Multiplicand = N'($urandom);
      Multiplier   = N'($urandom);
      tick();
    end
    add_s = 1'b0; sub_s = 1'b0; ashift_s = 1'b0; Request = 1'b0; Done = 1'b1;
    tick();
    run_cmp = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
